// File: rtl/regfile_sequencer_if.sv
// Command/response handshake bundle between the control path (master) and
// the register-file sequencer (slave).
interface regfile_sequencer_if #(
    parameter int REGISTER_SIZE = 8
);
    logic                     cmd_valid;
    logic                     cmd_ready;
    logic [1:0]               cmd_op;
    logic [3:0]               cmd_addr_a;
    logic [3:0]               cmd_addr_b;
    logic [REGISTER_SIZE-1:0] cmd_data;
    logic                     rsp_valid;
    logic                     rsp_ready;
    logic [REGISTER_SIZE-1:0] rsp_data;

    modport master (
        output cmd_valid, cmd_op, cmd_addr_a, cmd_addr_b, cmd_data, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_data
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_addr_a, cmd_addr_b, cmd_data, rsp_ready,
        output cmd_ready, rsp_valid, rsp_data
    );
endinterface

// File: rtl/regfile_sequencer.sv
// Sequences WRITE/READ/MOVE/CLEAR commands onto the 16x8 register unit pins.
// Define REGSEQ_MOVE_EN to support MOVE; otherwise op 10 takes a one-cycle err path.
module regfile_sequencer #(
    parameter int REGISTER_COUNT = 16,
    parameter int REGISTER_SIZE  = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    regfile_sequencer_if.slave       bus,
    output logic                     busy,
    output logic                     err,
    output logic                     rf_load,
    output logic                     rf_store,
    output logic [3:0]               rf_load_addr,
    output logic [3:0]               rf_store_addr,
    output logic [REGISTER_SIZE-1:0] rf_data_in,
    input  logic [REGISTER_SIZE-1:0] rf_data_out
);

    typedef enum logic [1:0] {
        OP_WRITE = 2'b00,
        OP_READ  = 2'b01,
        OP_MOVE  = 2'b10,
        OP_CLEAR = 2'b11
    } op_e;

    typedef enum logic [3:0] {
        IDLE,
        WR,
        RD_REQ,
        RD_CAP,
        RESP,
`ifdef REGSEQ_MOVE_EN
        MV_REQ,
        MV_CAP,
        MV_WR,
`endif
        CLR,
        ERR
    } state_e;

    localparam logic [3:0] LAST_ADDR = 4'(REGISTER_COUNT - 1);

    state_e     state;
    logic [3:0] counter;
`ifdef REGSEQ_MOVE_EN
    logic [3:0] addr_b_q;
`endif

    // Every output is registered and updated together with the state, so each
    // transition loads the values the destination state presents.
    // NOTE: sequential state uses non-blocking assignments only; a blocking
    // write here would let later statements see the new value and race other blocks.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            counter       <= 4'd0;
`ifdef REGSEQ_MOVE_EN
            addr_b_q      <= 4'd0;
`endif
            bus.cmd_ready <= 1'b1;
            bus.rsp_valid <= 1'b0;
            bus.rsp_data  <= '0;
            busy          <= 1'b0;
            err           <= 1'b0;
            rf_load       <= 1'b0;
            rf_store      <= 1'b0;
            rf_load_addr  <= 4'd0;
            rf_store_addr <= 4'd0;
            rf_data_in    <= '0;
        end else begin
            rf_load       <= 1'b0;
            rf_store      <= 1'b0;
            rf_load_addr  <= 4'd0;
            rf_store_addr <= 4'd0;
            rf_data_in    <= '0;
            err           <= 1'b0;

            case (state)
                IDLE: begin
                    if (bus.cmd_valid) begin
                        bus.cmd_ready <= 1'b0;
                        busy          <= 1'b1;
                        case (op_e'(bus.cmd_op))
                            OP_WRITE: begin
                                state        <= WR;
                                rf_load      <= 1'b1;
                                rf_load_addr <= bus.cmd_addr_a;
                                rf_data_in   <= bus.cmd_data;
                            end
                            OP_READ: begin
                                state         <= RD_REQ;
                                rf_store      <= 1'b1;
                                rf_store_addr <= bus.cmd_addr_a;
                            end
                            OP_MOVE: begin
`ifdef REGSEQ_MOVE_EN
                                state         <= MV_REQ;
                                rf_store      <= 1'b1;
                                rf_store_addr <= bus.cmd_addr_a;
                                addr_b_q      <= bus.cmd_addr_b;
`else
                                state <= ERR;
                                err   <= 1'b1;
`endif
                            end
                            default: begin
                                state        <= CLR;
                                rf_load      <= 1'b1;
                                rf_load_addr <= counter;
                            end
                        endcase
                    end
                end

                RD_REQ: state <= RD_CAP;

                RD_CAP: begin
                    state         <= RESP;
                    bus.rsp_data  <= rf_data_out;
                    bus.rsp_valid <= 1'b1;
                end

                RESP: begin
                    if (bus.rsp_ready) begin
                        state         <= IDLE;
                        bus.rsp_valid <= 1'b0;
                        bus.cmd_ready <= 1'b1;
                        busy          <= 1'b0;
                    end
                end

`ifdef REGSEQ_MOVE_EN
                MV_REQ: state <= MV_CAP;

                // The registered rf_data_in doubles as the temp holding the source value.
                MV_CAP: begin
                    state        <= MV_WR;
                    rf_load      <= 1'b1;
                    rf_load_addr <= addr_b_q;
                    rf_data_in   <= rf_data_out;
                end
`endif

                CLR: begin
                    if (counter == LAST_ADDR) begin
                        state         <= IDLE;
                        counter       <= 4'd0;
                        bus.cmd_ready <= 1'b1;
                        busy          <= 1'b0;
                    end else begin
                        counter      <= counter + 4'd1;
                        rf_load      <= 1'b1;
                        rf_load_addr <= counter + 4'd1;
                    end
                end

                // WR, MV_WR and ERR each last one cycle and return to IDLE.
                default: begin
                    state         <= IDLE;
                    bus.cmd_ready <= 1'b1;
                    busy          <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_sequencer.sv
// Randomized bench for regfile_sequencer: a behavioural register unit feeds the DUT,
// and an array model of the register contents predicts READ results and pin activity.
module tb_regfile_sequencer;

    localparam int REGS = 16;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       busy, err, rf_load, rf_store;
    logic [3:0] rf_load_addr, rf_store_addr;
    logic [7:0] rf_data_in, rf_data_out;

    regfile_sequencer_if #(.REGISTER_SIZE(8)) bus ();

    regfile_sequencer #(.REGISTER_COUNT(REGS), .REGISTER_SIZE(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (bus),
        .busy         (busy),
        .err          (err),
        .rf_load      (rf_load),
        .rf_store     (rf_store),
        .rf_load_addr (rf_load_addr),
        .rf_store_addr(rf_store_addr),
        .rf_data_in   (rf_data_in),
        .rf_data_out  (rf_data_out)
    );

    always #5 clk = ~clk;

    // Register unit stand-in: synchronous write, registered read.
    logic [7:0] rf_mem [REGS] = '{default: 8'h00};
    logic [7:0] rf_q = 8'h00;
    always @(posedge clk) begin
        if (rf_load)  rf_mem[rf_load_addr] <= rf_data_in;
        if (rf_store) rf_q <= rf_mem[rf_store_addr];
    end
    assign rf_data_out = rf_q;

    logic [7:0] ref_mem [REGS] = '{default: 8'h00};
    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_cmd_ready"}, 32'(bus.cmd_ready), 1);
        check({tag, "_busy"},      32'(busy), 0);
        check({tag, "_err"},       32'(err), 0);
        check({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 0);
        check({tag, "_rf_pins"},   {16'(rf_load), 8'(rf_store), 4'(rf_load_addr), 4'(rf_store_addr)}, 0);
        check({tag, "_rf_data"},   32'(rf_data_in), 0);
    endtask

    // Issues one command, follows it to completion and compares pin activity,
    // busy length, err pulses and any READ result with the model.
    task automatic run_cmd(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b,
                           input logic [7:0] d, input int hold);
        logic [11:0] exp_ld[$], got_ld[$];
        logic [3:0]  exp_st[$], got_st[$];
        logic [7:0]  exp_rsp;
        int exp_busy, exp_err, got_err, cycles, rsp_at, h_left, n;

        exp_err = 0;
        exp_rsp = ref_mem[a];
        case (op)
            2'b00: begin exp_busy = 1; exp_ld.push_back({a, d}); end
            2'b01: begin exp_busy = 3 + hold; exp_st.push_back(a); end
            2'b10: begin
`ifdef REGSEQ_MOVE_EN
                exp_busy = 3;
                exp_st.push_back(a);
                exp_ld.push_back({b, ref_mem[a]});
`else
                exp_busy = 1;
                exp_err  = 1;
`endif
            end
            default: begin
                exp_busy = REGS;
                for (int i = 0; i < REGS; i++) exp_ld.push_back({4'(i), 8'h00});
            end
        endcase

        n = 0;
        while (!bus.cmd_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check("ready_wait", 32'(bus.cmd_ready), 1);

        bus.cmd_valid  = 1'b1;
        bus.cmd_op     = op;
        bus.cmd_addr_a = a;
        bus.cmd_addr_b = b;
        bus.cmd_data   = d;
        @(posedge clk); #1;

        // A stray WRITE offered while busy must be ignored.
        bus.cmd_op     = 2'b00;
        bus.cmd_addr_a = 4'($urandom);
        bus.cmd_data   = 8'($urandom);

        got_err = 0; cycles = 0; rsp_at = 0; h_left = hold;
        while (busy && cycles < 100) begin
            cycles++;
            check("cmd_ready_busy", 32'(bus.cmd_ready), 0);
            check("ld_st_excl", 32'(rf_load & rf_store), 0);
            if (rf_load)  got_ld.push_back({rf_load_addr, rf_data_in});
            else          check("data_in_idle", 32'(rf_data_in), 0);
            if (rf_store) got_st.push_back(rf_store_addr);
            if (err)      got_err++;
            if (bus.rsp_valid) begin
                if (rsp_at == 0) rsp_at = cycles;
                check("rsp_data", 32'(bus.rsp_data), 32'(exp_rsp));
                if (h_left == 0) bus.rsp_ready = 1'b1;
                else             h_left--;
            end
            @(posedge clk); #1;
            bus.cmd_valid = 1'b0;
            bus.rsp_ready = 1'b0;
        end
        bus.cmd_valid = 1'b0;

        check("busy_cycles", 32'(cycles), 32'(exp_busy));
        check("ready_after", 32'(bus.cmd_ready), 1);
        check("rsp_valid_after", 32'(bus.rsp_valid), 0);
        check("err_pulses", 32'(got_err), 32'(exp_err));
        if (op == 2'b01) check("rsp_latency", 32'(rsp_at), 3);
        check("n_loads", 32'(got_ld.size()), 32'(exp_ld.size()));
        for (int i = 0; i < exp_ld.size() && i < got_ld.size(); i++)
            check("load_addr_data", 32'(got_ld[i]), 32'(exp_ld[i]));
        check("n_stores", 32'(got_st.size()), 32'(exp_st.size()));
        for (int i = 0; i < exp_st.size() && i < got_st.size(); i++)
            check("store_addr", 32'(got_st[i]), 32'(exp_st[i]));

        case (op)
            2'b00:   ref_mem[a] = d;
`ifdef REGSEQ_MOVE_EN
            2'b10:   ref_mem[b] = ref_mem[a];
`endif
            2'b11:   for (int i = 0; i < REGS; i++) ref_mem[i] = 8'h00;
            default: ;
        endcase
    endtask

    initial begin
        rst_n          = 1'b0;
        bus.cmd_valid  = 1'b0;
        bus.cmd_op     = 2'b00;
        bus.cmd_addr_a = 4'd0;
        bus.cmd_addr_b = 4'd0;
        bus.cmd_data   = 8'h00;
        bus.rsp_ready  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_idle_outputs("in_reset");
        check("rsp_data_reset", 32'(bus.rsp_data), 0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        check_idle_outputs("after_reset");

        // WRITE then READ with immediate and delayed consumer
        run_cmd(2'b00, 4'd3, 4'd0, 8'hA5, 0);
        run_cmd(2'b01, 4'd3, 4'd0, 8'h00, 0);
        run_cmd(2'b01, 4'd3, 4'd0, 8'h00, 5);

        // MOVE, with a distinct prior destination value
        run_cmd(2'b00, 4'd12, 4'd0, 8'h5A, 0);
        run_cmd(2'b00, 4'd7, 4'd0, 8'h3C, 0);
        run_cmd(2'b10, 4'd7, 4'd12, 8'h00, 0);
        run_cmd(2'b01, 4'd12, 4'd0, 8'h00, 1);
        run_cmd(2'b10, 4'd12, 4'd12, 8'h00, 0);
        run_cmd(2'b01, 4'd12, 4'd0, 8'h00, 0);

        // CLEAR across the full range
        run_cmd(2'b00, 4'd0, 4'd0, 8'h11, 0);
        run_cmd(2'b00, 4'd15, 4'd0, 8'hFF, 0);
        run_cmd(2'b11, 4'd0, 4'd0, 8'h00, 0);
        run_cmd(2'b01, 4'd0, 4'd0, 8'h00, 0);
        run_cmd(2'b01, 4'd15, 4'd0, 8'h00, 2);

        // Reset during the 8th CLR cycle, then a fresh CLEAR from address 0
        for (int i = 0; i < REGS; i++) run_cmd(2'b00, 4'(i), 4'd0, 8'(8'h80 + i), 0);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = 2'b11;
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        repeat (7) begin @(posedge clk); #1; end
        check("clr8_load", 32'(rf_load), 1);
        check("clr8_addr", 32'(rf_load_addr), 7);
        rst_n = 1'b0;
        #1;
        check_idle_outputs("mid_clear_reset");
        for (int i = 0; i < 7; i++) ref_mem[i] = 8'h00;
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        run_cmd(2'b01, 4'd7, 4'd0, 8'h00, 0);
        run_cmd(2'b01, 4'd6, 4'd0, 8'h00, 0);
        run_cmd(2'b11, 4'd0, 4'd0, 8'h00, 0);

        // Random traffic against the model
        for (int k = 0; k < 200; k++) begin
            logic [1:0] op;
            op = ($urandom_range(0, 15) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            run_cmd(op, 4'($urandom), 4'($urandom), 8'($urandom), int'($urandom_range(0, 3)));
        end
        for (int i = 0; i < REGS; i++) run_cmd(2'b01, 4'(i), 4'd0, 8'h00, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/regfile_sequencer.md
# regfile_sequencer

Command sequencer upstream of the 16×8 register unit: accepts WRITE/READ/MOVE/CLEAR commands over a valid/ready handshake and drives the register unit's load/store/address/data pins cycle-by-cycle. Consumes the register unit's registered read data and returns READ results over a response handshake. Sits between the control path and the register file; it is the only master of the register file's ports.

## Interface
- register_count, 16, number of registers addressed (addresses 0..register_count-1)
- register_size, 8, data width in bits
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  sequencer can accept (high only in IDLE)
- cmd_op  in  2  00 WRITE, 01 READ, 10 MOVE, 11 CLEAR
- cmd_addr_a  in  4  WRITE/READ target; MOVE source
- cmd_addr_b  in  4  MOVE destination
- cmd_data  in  register_size  WRITE data
- rsp_valid  out  1  READ result valid
- rsp_ready  in  1  consumer takes result
- rsp_data  out  register_size  READ result
- busy  out  1  high in every state except IDLE
- err  out  1  one-cycle pulse on an unsupported op
- rf_load  out  1  to register unit load
- rf_store  out  1  to register unit store (read request)
- rf_load_addr  out  4  write address
- rf_store_addr  out  4  read address
- rf_data_in  out  register_size  write data
- rf_data_out  in  register_size  register unit registered read data

## Operation
- Moore FSM; all rf_*, rsp_*, busy, err, cmd_ready decode from state/holding registers only.
- States: IDLE, WR, RD_REQ, RD_CAP, RESP, MV_REQ, MV_CAP, MV_WR, CLR, ERR.
- Accept on posedge with cmd_valid & cmd_ready; op, addr_a, addr_b, data latched into holding registers.
- WRITE: IDLE→WR; WR drives rf_load=1, rf_load_addr=addr_a, rf_data_in=data; →IDLE.
- READ: IDLE→RD_REQ (rf_store=1, rf_store_addr=addr_a) → RD_CAP (capture rf_data_out into rsp_data) → RESP (rsp_valid=1); RESP→IDLE on rsp_ready=1; holds otherwise, rsp_data stable.
- MOVE: IDLE→MV_REQ (rf_store=1, addr_a) → MV_CAP (capture into temp) → MV_WR (rf_load=1, rf_load_addr=addr_b, rf_data_in=temp) → IDLE. addr_a==addr_b is legal and rewrites the same value. rsp_valid stays 0.
- CLEAR: IDLE→CLR; 4-bit counter starts at 0; each CLR cycle drives rf_load=1, rf_load_addr=counter, rf_data_in=0, counter+1; leaves to IDLE after the cycle where counter==register_count-1; counter returns to 0.
- Addresses ≥ register_count are passed through unchecked.
- rf_load and rf_store are never high in the same cycle; outside the states above both are 0, and rf_data_in=0.
- cmd_valid while busy is ignored (no queueing).

## Timing
- Reset (async, reset=0): state IDLE; cmd_ready=1, busy=0, err=0, rsp_valid=0, rsp_data=0, rf_load=0, rf_store=0, rf_*_addr=0, rf_data_in=0, counter=0, temp=0.
- Reset mid-command: command abandoned, pending response discarded, partial CLEAR not resumed.
- WRITE: register updated at the 2nd posedge after acceptance; cmd_ready again 1 cycle after acceptance.
- READ: rsp_valid rises 3 cycles after the accept edge (RD_REQ, RD_CAP, RESP); earliest next accept is 1 cycle after the rsp handshake.
- MOVE: destination written at the 4th posedge after acceptance; 3 busy cycles.
- CLEAR: register_count busy cycles (16 by default).
- ERR: 1 busy cycle.

## Configuration
- REGSEQ_MOVE_EN defined: MOVE supported as above.
- Not defined: MV_* states and temp register absent; op 10 is accepted, goes IDLE→ERR (err=1 for exactly one cycle, no rf activity) →IDLE.

## Test plan
- Reset release -> cmd_ready=1, busy=0, all rf_* and rsp_* 0.
- WRITE addr 3 data 0xA5, then READ addr 3 with rsp_ready=1 -> rsp_valid 3 cycles after accept, rsp_data=0xA5.
- READ addr 3 with rsp_ready=0 for 5 cycles -> rsp_valid/rsp_data=0xA5 held, cmd_ready=0 throughout; accept resumes 1 cycle after rsp_ready.
- WRITE r7=0x3C; MOVE 7→12; READ 12 -> 0x3C; with REGSEQ_MOVE_EN undefined, MOVE -> single err pulse, READ 12 returns prior value.
- WRITE r0=0x11, r15=0xFF; CLEAR -> exactly 16 busy cycles, rf_load_addr 0..15; READ 0 and 15 -> 0x00.
- Assert reset=0 during the 8th CLR cycle -> immediate IDLE outputs; after release CLEAR restarts at address 0.
